// File: rtl/cbus_arbiter.sv
// Shares one data-bus memory port between instruction fetch and the memory stage.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT losses.
package cbus_pkg;
    typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  oreq,
    input  dbus_resp_t oresp
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    owner_t    sel;
    logic      grant;
    logic      fwd;
    logic      route;
    logic      force_i;
    logic      aok, dok;
    dbus_req_t req_i;

    assign force_i = (starve_q >= LIMIT);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        sel      = owner_q;
        grant    = 1'b0;
        fwd      = 1'b0;
        route    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dreq.valid && !(force_i && ireq.valid)) begin
                    grant = 1'b1;
                    sel   = OWN_D;
                end else if (ireq.valid) begin
                    grant = 1'b1;
                    sel   = OWN_I;
                end
                if (grant) begin
                    fwd     = 1'b1;
                    route   = 1'b1;
                    owner_d = sel;
                    if (oresp.addr_ok && oresp.data_ok) state_d = IDLE;
                    else if (oresp.addr_ok)             state_d = DATA;
                    else                                state_d = ADDR;
                    if (sel == OWN_I)
                        starve_d = '0;
                    else if (ireq.valid && starve_q != CNT_MAX)
                        starve_d = starve_q + 1'b1;
                end
            end
            ADDR: begin
                fwd   = 1'b1;
                route = 1'b1;
                if (oresp.addr_ok) state_d = oresp.data_ok ? IDLE : DATA;
            end
            DATA: begin
                route = 1'b1;
                if (oresp.data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Before the address is accepted a data_ok is a protocol error, so it is not passed on.
    always_comb begin
        req_i        = '0;
        req_i.valid  = ireq.valid;
        req_i.addr   = ireq.addr;
        req_i.size   = MSIZE4;
        aok          = route && oresp.addr_ok;
        dok          = route && oresp.data_ok && (state_q == DATA || oresp.addr_ok);
        oreq         = '0;
        iresp        = '0;
        dresp        = '0;
        if (fwd) oreq = (sel == OWN_D) ? dreq : req_i;
        iresp.data    = oresp.data;
        dresp.data    = oresp.data;
        iresp.addr_ok = aok && (sel == OWN_I);
        iresp.data_ok = dok && (sel == OWN_I);
        dresp.addr_ok = aok && (sel == OWN_D);
        dresp.data_ok = dok && (sel == OWN_D);
        if (reset) begin
            oreq  = '0;
            iresp = '0;
            dresp = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_D;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: vector table, directed corner sequences, then random traffic
// checked against a transaction-level reference model.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  oreq;
    dbus_resp_t oresp;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cbus_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    typedef struct {
        logic       rst;
        ibus_req_t  ir;
        dbus_req_t  dr;
        dbus_resp_t ors;
        dbus_req_t  e_oreq;
        ibus_resp_t e_iresp;
        dbus_resp_t e_dresp;
        int         e_cnt;
    } vec_t;

    vec_t vt[8];

    function automatic ibus_req_t mk_i(input logic v, input logic [31:0] a);
        ibus_req_t r;
        r.valid = v;
        r.addr  = a;
        return r;
    endfunction

    function automatic dbus_req_t mk_d(input logic v, input logic [31:0] a, input msize_t sz,
                                       input logic [3:0] st, input logic [31:0] d);
        dbus_req_t r;
        r.valid  = v;
        r.addr   = a;
        r.size   = sz;
        r.strobe = st;
        r.data   = d;
        return r;
    endfunction

    function automatic dbus_resp_t mk_r(input logic aok, input logic dok, input logic [31:0] d);
        dbus_resp_t r;
        r.addr_ok = aok;
        r.data_ok = dok;
        r.data    = d;
        return r;
    endfunction

    function automatic dbus_req_t ifetch(input logic [31:0] a);
        return mk_d(1'b1, a, MSIZE4, 4'h0, 32'h0);
    endfunction

    task automatic chk_o(input string name, input dbus_req_t act, input dbus_req_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: oreq got %h expected %h", name, act, exp);
    endtask

    task automatic chk_r(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: resp got %h expected %h", name, act, exp);
    endtask

    task automatic chk_v(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic r, input ibus_req_t ir, input dbus_req_t dr, input dbus_resp_t ors);
        @(negedge clk);
        reset = r;
        ireq  = ir;
        dreq  = dr;
        oresp = ors;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, '0, '0);
    endtask

    // Reference model state: phase 0 = free, 1 = waiting addr_ok, 2 = waiting data_ok.
    int m_phase;
    bit m_own_d;
    int m_cnt;

    task automatic run_random(input int cycles);
        logic       r;
        ibus_req_t  ir;
        dbus_req_t  dr;
        dbus_resp_t ors;
        dbus_req_t  eo;
        ibus_resp_t ei;
        dbus_resp_t ed;
        bit         win_d, active, fwd_req;
        for (int c = 0; c < cycles; c++) begin
            r   = (c == 0) || ($urandom_range(0, 63) == 0);
            ir  = mk_i(1'($urandom_range(0, 1)), $urandom);
            dr  = mk_d(1'($urandom_range(0, 1)), $urandom, msize_t'($urandom_range(0, 3)),
                       4'($urandom), $urandom);
            ors.data = $urandom;
            if (m_phase == 2 && !r) begin
                ors.addr_ok = 1'b0;
                ors.data_ok = ($urandom_range(0, 2) == 0);
            end else begin
                ors.addr_ok = 1'($urandom_range(0, 1));
                ors.data_ok = ors.addr_ok && ($urandom_range(0, 1) == 1);
            end
            drive(r, ir, dr, ors);

            if (r) begin
                m_phase = 0;
                m_own_d = 1'b1;
                m_cnt   = 0;
            end
            eo = '0;
            ei = '0;
            ed = '0;
            active  = 1'b0;
            fwd_req = 1'b0;
            win_d   = m_own_d;
            if (!r) begin
                ei.data = ors.data;
                ed.data = ors.data;
                if (m_phase == 0) begin
                    if (dr.valid && !(m_cnt >= 8 && ir.valid)) begin
                        active = 1'b1;
                        win_d  = 1'b1;
                    end else if (ir.valid) begin
                        active = 1'b1;
                        win_d  = 1'b0;
                    end
                    fwd_req = active;
                end else begin
                    active  = 1'b1;
                    fwd_req = (m_phase == 1);
                end
                if (fwd_req) eo = win_d ? dr : mk_d(ir.valid, ir.addr, MSIZE4, 4'h0, 32'h0);
                if (active) begin
                    if (win_d) begin
                        ed.addr_ok = ors.addr_ok;
                        ed.data_ok = ors.data_ok;
                    end else begin
                        ei.addr_ok = ors.addr_ok;
                        ei.data_ok = ors.data_ok;
                    end
                end
            end
            chk_o("rand_oreq", oreq, eo);
            chk_r("rand_iresp", iresp, ei);
            chk_r("rand_dresp", dresp, ed);
            chk_v("rand_cnt", int'(dut.starve_q), m_cnt);

            if (!r) begin
                if (m_phase == 0 && active) begin
                    m_own_d = win_d;
                    if (!win_d)        m_cnt = 0;
                    else if (ir.valid) m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
                    m_phase = ors.addr_ok ? (ors.data_ok ? 0 : 2) : 1;
                end else if (m_phase == 1) begin
                    if (ors.addr_ok) m_phase = ors.data_ok ? 0 : 2;
                end else if (m_phase == 2) begin
                    if (ors.data_ok) m_phase = 0;
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        dbus_req_t sw;
        reset = 1'b1;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        sw    = mk_d(1'b1, 32'h8000_0010, MSIZE4, 4'hF, 32'h1234_5678);

        vt[0] = '{1'b1, mk_i(1'b1, 32'hBFC0_0000), sw, mk_r(1'b1, 1'b1, 32'h2408_0001),
                  '0, '0, '0, 0};
        vt[1] = '{1'b0, mk_i(1'b1, 32'hBFC0_0000), '0, mk_r(1'b1, 1'b1, 32'h2408_0001),
                  ifetch(32'hBFC0_0000), mk_r(1'b1, 1'b1, 32'h2408_0001),
                  mk_r(1'b0, 1'b0, 32'h2408_0001), 0};
        vt[2] = '{1'b0, mk_i(1'b1, 32'hBFC0_0004), sw, mk_r(1'b1, 1'b1, 32'h0),
                  sw, mk_r(1'b0, 1'b0, 32'h0), mk_r(1'b1, 1'b1, 32'h0), 0};
        vt[3] = '{1'b0, '0, '0, mk_r(1'b0, 1'b0, 32'hDEAD_BEEF),
                  '0, mk_r(1'b0, 1'b0, 32'hDEAD_BEEF), mk_r(1'b0, 1'b0, 32'hDEAD_BEEF), 1};
        vt[4] = '{1'b0, mk_i(1'b1, 32'hBFC0_0008), '0, mk_r(1'b0, 1'b0, 32'h0),
                  ifetch(32'hBFC0_0008), mk_r(1'b0, 1'b0, 32'h0), mk_r(1'b0, 1'b0, 32'h0), 1};
        vt[5] = '{1'b0, mk_i(1'b1, 32'hBFC0_0008), sw, mk_r(1'b1, 1'b0, 32'h0),
                  ifetch(32'hBFC0_0008), mk_r(1'b1, 1'b0, 32'h0), mk_r(1'b0, 1'b0, 32'h0), 0};
        vt[6] = '{1'b0, '0, sw, mk_r(1'b0, 1'b1, 32'hCAFE_F00D),
                  '0, mk_r(1'b0, 1'b1, 32'hCAFE_F00D), mk_r(1'b0, 1'b0, 32'hCAFE_F00D), 0};
        vt[7] = '{1'b0, mk_i(1'b1, 32'hBFC0_000C), sw, mk_r(1'b1, 1'b1, 32'h0),
                  sw, mk_r(1'b0, 1'b0, 32'h0), mk_r(1'b1, 1'b1, 32'h0), 0};

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].rst, vt[i].ir, vt[i].dr, vt[i].ors);
            chk_o($sformatf("vec%0d_oreq", i), oreq, vt[i].e_oreq);
            chk_r($sformatf("vec%0d_iresp", i), iresp, vt[i].e_iresp);
            chk_r($sformatf("vec%0d_dresp", i), dresp, vt[i].e_dresp);
            chk_v($sformatf("vec%0d_cnt", i), int'(dut.starve_q), vt[i].e_cnt);
        end

        // Data owner stalls on addr_ok while fetch toggles, then split addr/data phases.
        do_reset();
        drive(1'b0, '0, sw, mk_r(1'b0, 1'b0, 32'h0));
        chk_o("stall_grant", oreq, sw);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, mk_i(1'(k % 2 == 0), 32'hBFC0_0000 + 32'(k * 4)), sw, mk_r(1'b0, 1'b0, 32'h0));
            chk_o($sformatf("stall_hold%0d", k), oreq, sw);
            chk_r($sformatf("stall_iresp%0d", k), iresp, mk_r(1'b0, 1'b0, 32'h0));
        end
        drive(1'b0, mk_i(1'b1, 32'hBFC0_0100), sw, mk_r(1'b1, 1'b0, 32'h0));
        chk_r("stall_aok", dresp, mk_r(1'b1, 1'b0, 32'h0));
        drive(1'b0, mk_i(1'b1, 32'hBFC0_0100), '0, mk_r(1'b0, 1'b0, 32'h0));
        chk_o("data_phase_idle_bus", oreq, '0);
        drive(1'b0, mk_i(1'b1, 32'hBFC0_0100), '0, mk_r(1'b0, 1'b1, 32'h0000_00AB));
        chk_r("data_phase_dok", dresp, mk_r(1'b0, 1'b1, 32'h0000_00AB));
        chk_r("data_phase_iresp", iresp, mk_r(1'b0, 1'b0, 32'h0000_00AB));
        drive(1'b0, mk_i(1'b1, 32'hBFC0_0100), '0, mk_r(1'b1, 1'b1, 32'h0));
        chk_o("after_data_regrant", oreq, ifetch(32'hBFC0_0100));

        // Anti-starvation: eight data wins, then a forced fetch grant, then data again.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, mk_i(1'b1, 32'hBFC0_0200), sw, mk_r(1'b1, 1'b1, 32'h0));
            chk_v($sformatf("starve_cnt%0d", k), int'(dut.starve_q), (k < 9) ? k : 0);
            chk_o($sformatf("starve_win%0d", k), oreq, (k == 8) ? ifetch(32'hBFC0_0200) : sw);
        end
        drive(1'b0, '0, '0, '0);
        chk_v("starve_cleared", int'(dut.starve_q), 1);

        // Reset while fetch owns the DATA phase.
        do_reset();
        drive(1'b0, mk_i(1'b1, 32'hBFC0_0300), '0, mk_r(1'b1, 1'b0, 32'h0));
        chk_r("rst_mid_aok", iresp, mk_r(1'b1, 1'b0, 32'h0));
        drive(1'b1, mk_i(1'b1, 32'hBFC0_0300), sw, mk_r(1'b0, 1'b1, 32'h5555_5555));
        chk_o("rst_mid_oreq", oreq, '0);
        chk_r("rst_mid_iresp", iresp, '0);
        drive(1'b0, '0, sw, mk_r(1'b1, 1'b1, 32'h0));
        chk_v("rst_mid_cnt", int'(dut.starve_q), 0);
        chk_o("rst_mid_newgrant", oreq, sw);
        chk_r("rst_mid_dresp", dresp, mk_r(1'b1, 1'b1, 32'h0));

        // Data owner drops valid before addr_ok; lock is kept.
        do_reset();
        drive(1'b0, '0, sw, mk_r(1'b0, 1'b0, 32'h0));
        chk_o("drop_grant", oreq, sw);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, mk_i(1'b1, 32'hBFC0_0400), '0, mk_r(1'b0, 1'b0, 32'h0));
            chk_o($sformatf("drop_oreq%0d", k), oreq, '0);
            chk_r($sformatf("drop_iresp%0d", k), iresp, mk_r(1'b0, 1'b0, 32'h0));
        end
        drive(1'b0, mk_i(1'b1, 32'hBFC0_0400), sw, mk_r(1'b1, 1'b1, 32'h0));
        chk_o("drop_resume", oreq, sw);
        chk_r("drop_done", dresp, mk_r(1'b1, 1'b1, 32'h0));
        drive(1'b0, mk_i(1'b1, 32'hBFC0_0400), '0, mk_r(1'b1, 1'b1, 32'h0));
        chk_o("drop_then_fetch", oreq, ifetch(32'hBFC0_0400));

        m_phase = 0;
        m_own_d = 1'b1;
        m_cnt   = 0;
        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
